vga_vscan_addr: RTL

VGA_VSCAN_ADDR -- requirements
Module: vga_vscan_addr

---
 rtl/vga_vscan_addr_pkg.sv | 47 ++++
 rtl/vga_vscan_addr_line_counter.sv | 65 ++++++
 rtl/vga_vscan_addr.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_vscan_addr_pkg.sv
// Vertical-scan timing constants and shared types for the VGA pipeline.
// The horizontal timing stage imports the same package so both stages agree on geometry.
package vga_vscan_addr_pkg;

  localparam int unsigned LINES_TOTAL = 521;
  localparam int unsigned VSYNC_LINES = 2;
  localparam int unsigned VDISP_FIRST = 31;
  localparam int unsigned VDISP_LAST  = 510;
  localparam int unsigned CELL_CLKS   = 10;
  localparam int unsigned CELL_LINES  = 5;
  localparam int unsigned COLS        = 128;
  localparam int unsigned ROWS        = 96;

  localparam int unsigned LINE_W   = 10;
  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned COL_W    = 7;
  localparam int unsigned SUBCOL_W = 4;
  localparam int unsigned SUBROW_W = 3;

  typedef logic [LINE_W-1:0]   line_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [COL_W-1:0]    col_t;
  typedef logic [SUBCOL_W-1:0] subcol_t;
  typedef logic [SUBROW_W-1:0] subrow_t;

  localparam line_t   LINE_LAST     = line_t'(LINES_TOTAL - 1);
  localparam line_t   VSYNC_LAST    = line_t'(VSYNC_LINES - 1);
  localparam line_t   VDISP_FIRST_L = line_t'(VDISP_FIRST);
  localparam line_t   VDISP_LAST_L  = line_t'(VDISP_LAST);
  localparam subcol_t SUBCOL_LAST   = subcol_t'(CELL_CLKS - 1);
  localparam subrow_t SUBROW_LAST   = subrow_t'(CELL_LINES - 1);
  localparam col_t    COL_LAST      = col_t'(COLS - 1);
  localparam addr_t   ROW_STEP      = addr_t'(COLS);
  localparam addr_t   ROW_BASE_LAST = addr_t'((ROWS - 1) * COLS);

  typedef enum logic {
    LC_WAIT_SYNC,
    LC_RUN
  } lc_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

endpackage

// File: rtl/vga_vscan_addr_line_counter.sv
// Line sync edge detect, frame line counter and registered vsync/vdisplay flags.
// Until the first hsync fall after reset the counter is unsynchronised: vsync idles high.
module vga_line_counter
  import vga_vscan_addr_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hsync_i,
  output logic  line_start_o,
  output line_t line_o,
  output logic  vsync_o,
  output logic  vdisplay_o
);

  lc_state_e state_q;
  logic      hsync_prev_q;
  line_t     line_q;
  logic      vsync_q;
  logic      vdisplay_q;
  logic      line_start;

  assign line_start = hsync_prev_q & ~hsync_i;

  // Flags are computed from the line being entered so they change with line_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LC_WAIT_SYNC;
      hsync_prev_q <= 1'b1;
      line_q       <= '0;
      vsync_q      <= 1'b1;
      vdisplay_q   <= 1'b0;
    end else begin
      hsync_prev_q <= hsync_i;
      if (line_start) begin
        case (state_q)
          LC_WAIT_SYNC: begin
            state_q    <= LC_RUN;
            line_q     <= '0;
            vsync_q    <= 1'b0;
            vdisplay_q <= 1'b0;
          end
          LC_RUN: begin
            if (line_q == LINE_LAST) begin
              line_q     <= '0;
              vsync_q    <= 1'b0;
              vdisplay_q <= 1'b0;
            end else begin
              line_q     <= line_q + line_t'(1);
              vsync_q    <= (line_q >= VSYNC_LAST);
              vdisplay_q <= (line_q >= (VDISP_FIRST_L - line_t'(1))) &&
                            (line_q < VDISP_LAST_L);
            end
          end
          default: state_q <= LC_WAIT_SYNC;
        endcase
      end
    end
  end

  assign line_start_o = line_start;
  assign line_o       = line_q;
  assign vsync_o      = vsync_q;
  assign vdisplay_o   = vdisplay_q;

endmodule

// File: rtl/vga_vscan_addr.sv
// Vertical scan and framebuffer addressing for a 128x96 cell display on 640x480 VGA.
// Generates VRAM read addresses and re-times colour and both syncs onto one output edge.
module vga_vscan_addr
  import vga_vscan_addr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              display_time,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [2:0]        vram_data,
  output logic              vga_red,
  output logic              vga_green,
  output logic              vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync
);

  logic    line_start;
  line_t   line_cnt;
  logic    vsync_int;
  logic    vdisplay;
  logic    active;
  logic    row_first;
  logic    row_adv;

  subcol_t subcol_q, subcol_d;
  col_t    col_q, col_d;
  subrow_t subrow_q, subrow_d;
  addr_t   row_base_q, row_base_d;
  addr_t   addr_q, addr_d;

  logic [1:0] active_q;
  logic [1:0] hsync_q;
  logic       vsync_q;
  rgb_t       rgb_q;
  logic       hsync_out_q;
  logic       vsync_out_q;

  vga_line_counter u_line_counter (
    .clk          (clk),
    .reset        (reset),
    .hsync_i      (hsync_in),
    .line_start_o (line_start),
    .line_o       (line_cnt),
    .vsync_o      (vsync_int),
    .vdisplay_o   (vdisplay)
  );

  assign active = display_time & vdisplay;

  // line_cnt still holds the previous line while line_start is high.
  assign row_first = line_start && (line_cnt == (VDISP_FIRST_L - line_t'(1)));
  assign row_adv   = line_start && vdisplay && (line_cnt != VDISP_LAST_L);

  always_comb begin
    subcol_d   = subcol_q;
    col_d      = col_q;
    subrow_d   = subrow_q;
    row_base_d = row_base_q;
    addr_d     = '0;

    if (line_start || !active) begin
      subcol_d = '0;
      col_d    = '0;
    end else if (subcol_q == SUBCOL_LAST) begin
      subcol_d = '0;
      if (col_q != COL_LAST) begin
        col_d = col_q + col_t'(1);
      end
    end else begin
      subcol_d = subcol_q + subcol_t'(1);
    end

    if (row_first) begin
      subrow_d   = '0;
      row_base_d = '0;
    end else if (row_adv) begin
      if (subrow_q == SUBROW_LAST) begin
        subrow_d = '0;
        if (row_base_q != ROW_BASE_LAST) begin
          row_base_d = row_base_q + ROW_STEP;
        end
      end else begin
        subrow_d = subrow_q + subrow_t'(1);
      end
    end

    if (active) begin
      addr_d = row_base_q + addr_t'(col_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subcol_q    <= '0;
      col_q       <= '0;
      subrow_q    <= '0;
      row_base_q  <= '0;
      addr_q      <= '0;
      active_q    <= '0;
      hsync_q     <= '1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
    end else begin
      subcol_q    <= subcol_d;
      col_q       <= col_d;
      subrow_q    <= subrow_d;
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      active_q    <= {active_q[0], active};
      hsync_q     <= {hsync_q[0], hsync_in};
      vsync_q     <= vsync_int;
      rgb_q       <= active_q[1] ? rgb_t'(vram_data) : '0;
      hsync_out_q <= hsync_q[1];
      vsync_out_q <= vsync_q;
    end
  end

  assign vram_addr = addr_q;
  assign vga_red   = rgb_q.r;
  assign vga_green = rgb_q.g;
  assign vga_blue  = rgb_q.b;
  assign vga_hsync = hsync_out_q;
  assign vga_vsync = vsync_out_q;

endmodule
